maxpool2d_param_packed: RTL and testbench
=========================================

# maxpool2d_param_packed

Parametrised 2-D pooling engine for the CNN accelerator datapath. It walks a CHW feature map held in an upstream layer's output memory through a registered read port. It reduces each POOL×POOL window (stride = POOL) by max or average and packs PACK results per word into an internal output RAM. The next layer reads that RAM through a nibble-addressed read port. It generalises the fixed 2×2/4-bit/packed-by-8 pooling stages to arbitrary size, data width, channel count and reduction mode.

## Interface
Parameters:
- DATA_W, 4, element width (unsigned).
- IN_H, 16, input rows.
- IN_W, 16, input columns.
- CHANNELS, 64, channel count.
- POOL, 2, window edge and stride; power of two, ≥2.
- PACK, 8, elements per output RAM word; word width = PACK*DATA_W.
- ADDR_W, 32, address width for both read ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM, counters and outputs (RAM contents untouched).
- start  in  1  pulse; sampled only in IDLE.
- mode  in  1  0 = max, 1 = average; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- src_rd_en  out  1  upstream read strobe.
- src_addr  out  ADDR_W  upstream element address.
- src_data  in  DATA_W  upstream data, valid exactly one cycle after src_rd_en.
- read_addr  in  ADDR_W  output element index for the downstream reader.
- read_data  out  DATA_W  element at read_addr, one-cycle registered latency.

## Operation
- Derived values: OH = IN_H/POOL, OW = IN_W/POOL (floor; leftover rows/cols ignored), K = POOL*POOL, N = CHANNELS*OH*OW, DEPTH = ceil(N/PACK).
- Input address: ch*IN_H*IN_W + row*IN_W + col.
- Output element index: e = ch*OH*OW + orow*OW + ocol. It is stored in word e/PACK, lane e%PACK. Lane 0 occupies the MSBs: bits [PACK*DATA_W-1 -: DATA_W].
- Element order: ch outer, then orow, then ocol. Window reads are row-major within the window.
- Max mode: unsigned compare; the first sample seeds the accumulator.
- Average mode: sum in DATA_W+log2(K) bits, then result = sum >> log2(K) (floor, no rounding).
- FSM states and transitions:
  - IDLE → FETCH on start.
  - FETCH issues K reads on K consecutive cycles.
  - DRAIN captures the last sample.
  - EMIT places the result in the pack register. It writes the RAM when lane == PACK-1 or e == N-1, then clears the pack register, so unused lanes of the final partial word are 0.
  - EMIT → FETCH for the next element, or → DONE after e == N-1.
  - DONE → IDLE, with done high for that one cycle.
- Outputs in IDLE: src_rd_en = 0. src_addr holds its last value.
- start while busy is ignored. mode changes while busy are ignored.
- The read port is always live. Words not yet written in the current run return prior contents.
- Same-cycle RAM write and read of one word returns old data (read-first).
- Reset mid-run returns to IDLE immediately. The partially written RAM is left as is. A following start recomputes everything.

## Timing
- Reset values: busy = 0, done = 0, src_rd_en = 0, src_addr = 0, read_data = 0.
- Per element: K+2 cycles (K FETCH, 1 DRAIN, 1 EMIT).
- done pulses on the edge N*(K+2)+1 cycles after the edge that samples start. busy falls on the same edge done rises.
- RAM write occurs in the EMIT cycle and is visible on read_data two edges later.
- read_data latency is 1 cycle from read_addr.

## Test plan
- Defaults, mode = 0, src_data = src_addr[3:0] → RAM word 0 = 0x13579BDF; every channel's words alternate 0x13579BDF / 0x13579BDF; done fires once.
- Defaults, mode = 1, same stimulus → word 0 = 0x02468ACE (window {2c, 2c+1, 2c, 2c+1} averages to 2c).
- Cycle count, defaults: done rises exactly 64*64*6+1 = 24577 edges after start is sampled; busy is high for the whole interval.
- CHANNELS = 1, IN_H = IN_W = 7, POOL = 2 (OH = OW = 3, N = 9, row/col 6 ignored) → 2 words; word 1 lanes 1-7 = 0, lane 0 = pool of rows 4-5, cols 4-5.
- Assert reset at cycle 100 of a run → busy, done, src_rd_en = 0 immediately with no done pulse. A new start then completes with correct data.
- Pulse start again at cycle 50 of a run and toggle mode → ignored; a single done; results match the original mode.

Source files
------------

// File: rtl/maxpool2d_param_packed.sv
// POOLxPOOL max/average pooling over a CHW feature map, packing PACK results
// per word into an internal RAM exposed through an element-indexed read port.
module maxpool2d_param_packed #(
    parameter int DATA_W   = 4,
    parameter int IN_H     = 16,
    parameter int IN_W     = 16,
    parameter int CHANNELS = 64,
    parameter int POOL     = 2,
    parameter int PACK     = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);
    localparam int OH     = IN_H / POOL;
    localparam int OW     = IN_W / POOL;
    localparam int K      = POOL * POOL;
    localparam int LOGK   = $clog2(K);
    localparam int N      = CHANNELS * OH * OW;
    localparam int DEPTH  = (N + PACK - 1) / PACK;
    localparam int WORD_W = PACK * DATA_W;
    localparam int ACC_W  = DATA_W + LOGK;
    localparam int CH_W   = $clog2(CHANNELS + 1);
    localparam int ROW_W  = $clog2(OH + 1);
    localparam int COL_W  = $clog2(OW + 1);
    localparam int WIN_W  = $clog2(K + 1);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ROW_W-1:0]  orow_q, orow_d;
    logic [COL_W-1:0]  ocol_q, ocol_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WA_W-1:0]   word_q, word_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] ins;
    logic [DATA_W-1:0] res;
    logic              last_elem;
    logic              wr_en;
    logic [WA_W-1:0]   rd_word;
    logic [LANE_W-1:0] rd_lane;
    logic [WORD_W-1:0] rd_row;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        win_d     = win_q;
        lane_d    = lane_q;
        word_d    = word_q;
        acc_d     = acc_q;
        pack_d    = pack_q;
        mode_d    = mode_q;
        wr_en     = 1'b0;
        last_elem = (ch_q == CH_W'(CHANNELS - 1)) && (orow_q == ROW_W'(OH - 1)) &&
                    (ocol_q == COL_W'(OW - 1));
        res       = mode_q ? DATA_W'(acc_q >> LOGK) : acc_q[DATA_W-1:0];
        ins       = pack_q;
        for (int unsigned l = 0; l < PACK; l++) begin
            if (LANE_W'(l) == lane_q) ins[(PACK-1-l)*DATA_W +: DATA_W] = res;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ch_d    = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                    win_d   = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    pack_d  = '0;
                    mode_d  = mode;
                end
            end
            S_FETCH: begin
                if (win_q == WIN_W'(K - 1)) state_d = S_DRAIN;
                else                        win_d   = win_q + WIN_W'(1);
            end
            S_DRAIN: state_d = S_EMIT;
            S_EMIT: begin
                win_d = '0;
                if (lane_q == LANE_W'(PACK - 1) || last_elem) begin
                    wr_en  = 1'b1;
                    pack_d = '0;
                    lane_d = '0;
                    word_d = word_q + WA_W'(1);
                end else begin
                    pack_d = ins;
                    lane_d = lane_q + LANE_W'(1);
                end
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    if (ocol_q == COL_W'(OW - 1)) begin
                        ocol_d = '0;
                        if (orow_q == ROW_W'(OH - 1)) begin
                            orow_d = '0;
                            ch_d   = ch_q + CH_W'(1);
                        end else begin
                            orow_d = orow_q + ROW_W'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + COL_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Sample for the read issued last cycle; the one arriving at window slot 1 seeds.
        if ((state_q == S_FETCH && win_q != '0) || state_q == S_DRAIN) begin
            if (state_q == S_FETCH && win_q == WIN_W'(1)) acc_d = ACC_W'(src_data);
            else if (mode_q)                              acc_d = acc_q + ACC_W'(src_data);
            else if (ACC_W'(src_data) > acc_q)            acc_d = ACC_W'(src_data);
        end

        // Read strobe/address are registered from next-state so they align with FETCH cycles.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_DONE);
        rd_en_d = (state_d == S_FETCH);
        addr_d  = addr_q;
        if (rd_en_d) begin
            addr_d = ADDR_W'(ch_d) * ADDR_W'(IN_H * IN_W)
                   + (ADDR_W'(orow_d) * ADDR_W'(POOL) + ADDR_W'(win_d / WIN_W'(POOL))) * ADDR_W'(IN_W)
                   + ADDR_W'(ocol_d) * ADDR_W'(POOL) + ADDR_W'(win_d % WIN_W'(POOL));
        end
    end

    always_comb begin
        rd_word = WA_W'(read_addr / ADDR_W'(PACK));
        rd_lane = LANE_W'(read_addr % ADDR_W'(PACK));
        rd_row  = mem_q[rd_word];
        rdata_d = '0;
        if (read_addr < ADDR_W'(DEPTH * PACK)) begin
            for (int unsigned l = 0; l < PACK; l++) begin
                if (LANE_W'(l) == rd_lane) rdata_d = rd_row[(PACK-1-l)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[word_q] <= ins;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            win_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            acc_q   <= '0;
            pack_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            win_q   <= win_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            pack_q  <= pack_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign src_rd_en = rd_en_q;
    assign src_addr  = addr_q;
    assign read_data = rdata_q;
endmodule

// File: tb/tb_maxpool2d_param_packed.sv
// Bench for maxpool2d_param_packed: a default-size instance and a 7x7 single-channel
// instance, each fed by a registered source memory and checked against a window model.
module tb_maxpool2d_param_packed;
    localparam int N_A   = 64 * 8 * 8;
    localparam int N_B   = 9;
    localparam int CYC_A = N_A * 6 + 1;
    localparam int CYC_B = N_B * 6 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, start_a = 1'b0, mode_a = 1'b0;
    logic        busy_a, done_a, src_rd_en_a;
    logic [31:0] src_addr_a, read_addr_a = '0;
    logic [3:0]  src_data_a = '0, read_data_a;
    logic        rst_b = 1'b1, start_b = 1'b0, mode_b = 1'b0;
    logic        busy_b, done_b, src_rd_en_b;
    logic [31:0] src_addr_b, read_addr_b = '0;
    logic [3:0]  src_data_b = '0, read_data_b;

    logic [3:0] mem_a [16384];
    logic [3:0] mem_b [64];
    logic [3:0] got   [16384];

    int n_vec = 0;
    int n_err = 0;

    maxpool2d_param_packed dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .mode(mode_a),
        .busy(busy_a), .done(done_a), .src_rd_en(src_rd_en_a), .src_addr(src_addr_a),
        .src_data(src_data_a), .read_addr(read_addr_a), .read_data(read_data_a)
    );

    maxpool2d_param_packed #(
        .DATA_W(4), .IN_H(7), .IN_W(7), .CHANNELS(1), .POOL(2), .PACK(8), .ADDR_W(32)
    ) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .mode(mode_b),
        .busy(busy_b), .done(done_b), .src_rd_en(src_rd_en_b), .src_addr(src_addr_b),
        .src_data(src_data_b), .read_addr(read_addr_b), .read_data(read_data_b)
    );

    always @(posedge clk) begin
        if (src_rd_en_a) src_data_a <= mem_a[src_addr_a[13:0]];
        if (src_rd_en_b) src_data_b <= mem_b[src_addr_b[5:0]];
    end

    // Reference: pool the 2x2 window of output element e straight from the source memory.
    function automatic logic [3:0] ref_elem(input bit sel, input int e, input bit m);
        int dim, oh, n, ch, orow, ocol, a, v, mx, sum;
        dim = sel ? 7 : 16;
        oh  = dim / 2;
        n   = (sel ? 1 : 64) * oh * oh;
        if (e >= n) return 4'd0;
        ch   = e / (oh * oh);
        orow = (e / oh) % oh;
        ocol = e % oh;
        mx   = 0;
        sum  = 0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                a = ch * dim * dim + (orow * 2 + dr) * dim + ocol * 2 + dc;
                v = sel ? int'(mem_b[a]) : int'(mem_a[a]);
                if (v > mx) mx = v;
                sum += v;
            end
        end
        return m ? 4'(sum / 4) : 4'(mx);
    endfunction

    task automatic run(input bit sel, input bit m, input bit repulse, input int limit,
                       output int cyc, output int busy_low, output int extra_done,
                       output bit busy_at_done, output bit timed_out);
        cyc = 0; busy_low = 0; extra_done = 0; busy_at_done = 1'b1; timed_out = 1'b0;
        @(negedge clk);
        if (sel) begin mode_b = m; start_b = 1'b1; end
        else     begin mode_a = m; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (!(sel ? busy_b : busy_a)) busy_low++;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (sel ? done_b : done_a) begin
                busy_at_done = sel ? busy_b : busy_a;
                break;
            end
            if (!(sel ? busy_b : busy_a)) busy_low++;
            if (repulse && cyc == 50) begin start_a = 1'b1; mode_a = !m; end
            if (repulse && cyc == 51) start_a = 1'b0;
            if (cyc >= limit) begin timed_out = 1'b1; break; end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (sel ? done_b : done_a) extra_done++;
        end
    endtask

    task automatic readback(input bit sel, input int cnt);
        for (int e = 0; e < cnt; e++) begin
            @(negedge clk);
            if (sel) read_addr_b = e; else read_addr_a = e;
            @(posedge clk); #1;
            got[e] = sel ? read_data_b : read_data_a;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy_a !== 1'b0)      begin n_err++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        n_vec++; if (done_a !== 1'b0)      begin n_err++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
        n_vec++; if (src_rd_en_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_en_a: got %b expected 0", src_rd_en_a); end
        n_vec++; if (src_addr_a !== 32'd0) begin n_err++; $display("FAIL reset_addr_a: got %0h expected 0", src_addr_a); end
        n_vec++; if (read_data_a !== 4'd0) begin n_err++; $display("FAIL reset_rdata_a: got %0h expected 0", read_data_a); end
        n_vec++; if (busy_b !== 1'b0)      begin n_err++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        n_vec++; if (done_b !== 1'b0)      begin n_err++; $display("FAIL reset_done_b: got %b expected 0", done_b); end
        n_vec++; if (src_rd_en_b !== 1'b0) begin n_err++; $display("FAIL reset_rd_en_b: got %b expected 0", src_rd_en_b); end
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_max_restart_ignored;
        int cyc, bl, xd; bit bad, to; logic [31:0] w0, w1;
        for (int i = 0; i < 16384; i++) mem_a[i] = 4'(i);
        run(1'b0, 1'b0, 1'b1, CYC_A + 100, cyc, bl, xd, bad, to);
        n_vec++; if (to)          begin n_err++; $display("FAIL max_timeout: no done within %0d cycles", CYC_A + 100); end
        n_vec++; if (cyc != CYC_A) begin n_err++; $display("FAIL max_latency: got %0d expected %0d", cyc, CYC_A); end
        n_vec++; if (bl != 0)     begin n_err++; $display("FAIL max_busy_gap: got %0d low cycles expected 0", bl); end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL max_busy_at_done: got %b expected 0", bad); end
        n_vec++; if (xd != 0)     begin n_err++; $display("FAIL max_done_once: got %0d extra pulses expected 0", xd); end
        readback(1'b0, N_A);
        for (int e = 0; e < N_A; e++) begin
            n_vec++;
            if (got[e] !== ref_elem(1'b0, e, 1'b0)) begin
                n_err++; $display("FAIL max_elem[%0d]: got %0h expected %0h", e, got[e], ref_elem(1'b0, e, 1'b0));
            end
        end
        w0 = '0; w1 = '0;
        for (int i = 0; i < 8; i++) begin
            w0 = (w0 << 4) | 32'(got[i]);
            w1 = (w1 << 4) | 32'(got[8 + i]);
        end
        n_vec++; if (w0 !== 32'h13579BDF) begin n_err++; $display("FAIL max_word0: got %h expected 13579bdf", w0); end
        n_vec++; if (w1 !== 32'h13579BDF) begin n_err++; $display("FAIL max_word1: got %h expected 13579bdf", w1); end
    endtask

    task automatic test_reset_midrun;
        int cyc, bl, xd, stray; bit bad, to; logic [31:0] w0;
        for (int i = 0; i < 16384; i++) mem_a[i] = 4'($urandom);
        @(negedge clk);
        mode_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_a = 1'b1;
        #1;
        n_vec++; if (busy_a !== 1'b0)      begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
        n_vec++; if (done_a !== 1'b0)      begin n_err++; $display("FAIL midreset_done: got %b expected 0", done_a); end
        n_vec++; if (src_rd_en_a !== 1'b0) begin n_err++; $display("FAIL midreset_rd_en: got %b expected 0", src_rd_en_a); end
        @(negedge clk);
        rst_a = 1'b0;
        stray = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a || busy_a) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray); end

        for (int i = 0; i < 16384; i++) mem_a[i] = 4'(i);
        run(1'b0, 1'b1, 1'b0, CYC_A + 100, cyc, bl, xd, bad, to);
        n_vec++; if (to)           begin n_err++; $display("FAIL avg_timeout: no done within %0d cycles", CYC_A + 100); end
        n_vec++; if (cyc != CYC_A) begin n_err++; $display("FAIL avg_latency: got %0d expected %0d", cyc, CYC_A); end
        n_vec++; if (xd != 0)      begin n_err++; $display("FAIL avg_done_once: got %0d extra pulses expected 0", xd); end
        readback(1'b0, N_A);
        for (int e = 0; e < N_A; e++) begin
            n_vec++;
            if (got[e] !== ref_elem(1'b0, e, 1'b1)) begin
                n_err++; $display("FAIL avg_elem[%0d]: got %0h expected %0h", e, got[e], ref_elem(1'b0, e, 1'b1));
            end
        end
        w0 = '0;
        for (int i = 0; i < 8; i++) w0 = (w0 << 4) | 32'(got[i]);
        n_vec++; if (w0 !== 32'h02468ACE) begin n_err++; $display("FAIL avg_word0: got %h expected 02468ace", w0); end
    endtask

    task automatic test_partial_word_random;
        int cyc, bl, xd; bit bad, to, m; logic [27:0] tail;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) mem_b[i] = 4'($urandom);
            m = (r % 2) == 1;
            run(1'b1, m, 1'b0, CYC_B + 50, cyc, bl, xd, bad, to);
            n_vec++; if (to || cyc != CYC_B) begin n_err++; $display("FAIL small_latency[%0d]: got %0d expected %0d", r, cyc, CYC_B); end
            n_vec++; if (bl != 0 || bad !== 1'b0 || xd != 0) begin
                n_err++; $display("FAIL small_handshake[%0d]: busy_low %0d busy_at_done %b extra_done %0d expected 0 0 0", r, bl, bad, xd);
            end
            readback(1'b1, 16);
            for (int e = 0; e < 16; e++) begin
                n_vec++;
                if (got[e] !== ref_elem(1'b1, e, m)) begin
                    n_err++; $display("FAIL small_elem[%0d][%0d]: got %0h expected %0h", r, e, got[e], ref_elem(1'b1, e, m));
                end
            end
            tail = '0;
            for (int i = 9; i < 16; i++) tail = (tail << 4) | 28'(got[i]);
            n_vec++; if (tail !== 28'd0) begin n_err++; $display("FAIL small_tail_lanes[%0d]: got %h expected 0", r, tail); end
        end
    endtask

    initial begin
        test_reset;
        test_partial_word_random;
        test_max_restart_ignored;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
